// File: rtl/div_nr32_pkg.sv
// Shared definitions for the iterative non-restoring divider: FSM states,
// step count, special-case constants and arithmetic helpers.
package div_nr32_pkg;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_PREP,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    localparam int unsigned DIV_STEPS     = 32;
    localparam logic [5:0]  DIV_LAST_STEP = 6'(DIV_STEPS - 1);
    localparam logic [31:0] DIV_ZERO_QUOT = '1;
    localparam logic [31:0] DIV_MIN_INT   = 32'h8000_0000;
    localparam logic [31:0] DIV_NEG_ONE   = '1;

    // Two's-complement converter: conditional negation with wrap.
    function automatic logic [31:0] tcc(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // 33-bit add/subtract with wrap.
    function automatic logic [32:0] add33(input logic [32:0] a, input logic [32:0] b,
                                          input logic sub);
        return sub ? (a + ~b + 33'd1) : (a + b);
    endfunction

endpackage

// File: rtl/div_nr_step.sv
// One combinational non-restoring radix-2 step on the {P, Q} pair.
module div_nr_step
    import div_nr32_pkg::*;
(
    input  logic [32:0] p,
    input  logic [31:0] q,
    input  logic [31:0] d,
    output logic [32:0] p_next,
    output logic [31:0] q_next
);

    logic [32:0] p_sh;

    // Add/subtract choice uses the sign before the shift; the shifted value
    // may wrap in 33 bits, but the result lands back in [-D, D) so it is exact.
    always_comb begin
        p_sh   = {p[31:0], q[31]};
        p_next = add33(p_sh, {1'b0, d}, ~p[32]);
        q_next = {q[30:0], ~p_next[32]};
    end

endmodule

// File: rtl/div_nr32.sv
// Iterative 32-bit signed/unsigned divider, one non-restoring step per cycle,
// with valid/ready handshakes on operands and results.
module div_nr32
    import div_nr32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        busy
);

    div_state_t  state;
    logic [5:0]  cnt;
    logic [32:0] p;
    logic [31:0] q;
    logic [31:0] d;
    logic        sgn;
    logic        sq;
    logic        sr;
    logic [32:0] p_step;
    logic [31:0] q_step;

    div_nr_step u_step (
        .p      (p),
        .q      (q),
        .d      (d),
        .p_next (p_step),
        .q_next (q_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            p         <= '0;
            q         <= '0;
            d         <= '0;
            sgn       <= 1'b0;
            sq        <= 1'b0;
            sr        <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (in_valid) begin
                        q        <= dividend;
                        d        <= divisor;
                        sgn      <= is_signed;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DIV_PREP;
                    end
                end
                DIV_PREP: begin
                    sq  <= sgn & (q[31] ^ d[31]);
                    sr  <= sgn & q[31];
                    q   <= tcc(q, sgn & q[31]);
                    d   <= tcc(d, sgn & d[31]);
                    p   <= '0;
                    cnt <= '0;
                    // Special cases are decided on the original operands.
                    if (d == '0) begin
                        quot      <= DIV_ZERO_QUOT;
                        rem       <= q;
                        out_valid <= 1'b1;
                        state     <= DIV_DONE;
                    end else if (sgn && q == DIV_MIN_INT && d == DIV_NEG_ONE) begin
                        quot      <= DIV_MIN_INT;
                        rem       <= '0;
                        out_valid <= 1'b1;
                        state     <= DIV_DONE;
                    end else begin
                        state <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    p   <= p_step;
                    q   <= q_step;
                    cnt <= cnt + 6'd1;
                    if (cnt == DIV_LAST_STEP) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    quot      <= tcc(q, sq);
                    rem       <= tcc(p[32] ? (p[31:0] + d) : p[31:0], sr);
                    out_valid <= 1'b1;
                    state     <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DIV_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_nr32.sv
// Scoreboard bench for div_nr32: expected results are queued at issue and
// compared, with latency, when the divider presents them.
module tb_div_nr32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        busy;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    div_nr32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.lat = 1;
        end else if (s) begin
            e.q = sa / sb; e.r = sa % sb; e.lat = 34;
        end else begin
            e.q = a / b; e.r = a % b; e.lat = 34;
        end
        return e;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        sbq.push_back(model(a, b, s));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = $urandom_range(0, 1) == 1;
    endtask

    task automatic wait_result(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_seen"}, 32'(out_valid), 32'd1);
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
            chk({tag, "_quot"}, quot, e.q);
            chk({tag, "_rem"}, rem, e.r);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s);
        start_op(a, b, s);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_result(tag);
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] hq;
        logic [31:0] hr;
        int          seen;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem", rem, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("s100_7", 32'd100, 32'd7, 1'b1);
        run_op("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op("uffff_2", 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op("sffff_2", 32'hFFFF_FFFF, 32'd2, 1'b1);
        run_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op("udiv0", 32'd1234, 32'd0, 1'b0);
        run_op("sdiv0", 32'hFFFF_FF00, 32'd0, 1'b1);
        run_op("umin_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("smin_1", 32'h8000_0000, 32'd1, 1'b1);
        run_op("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("u5_9", 32'd5, 32'd9, 1'b0);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        start_op(32'd1000, 32'd33, 1'b0);
        hq = 32'd1000 / 32'd33;
        hr = 32'd1000 % 32'd33;
        wait_result("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_quot", quot, hq);
            chk("bp_rem", rem, hr);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of CALC: accept edge E0, step 15 at E17.
        start_op(32'd100, 32'd7, 1'b1);
        repeat (17) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_quot", quot, 32'd0);
        chk("mrst_rem", rem, 32'd0);
        void'(sbq.pop_back());
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mrst_no_emit", 32'(seen), 32'd0);
        run_op("post_rst_9_3", 32'd9, 32'd3, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
            if (i == 7) rb = 32'd0;
            run_op("rand", ra, rb, $urandom_range(0, 1) == 1);
        end

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
